// File: rtl/flp_tree_sequencer.sv
// flp_tree_sequencer: loads NUM_INPUTS codes onto the adder-tree bus, waits out the tree latency, then offers the captured sum.
// Ports: flush_i aborts to LOAD; in_valid_i/in_ready_o/in_data_i element stream; tree_bus_o packed tree operands;
// tree_exp_i/tree_mant_i tree result; sum_valid_o/sum_ready_i/sum_exp_o/sum_mant_o result stream; busy_o in WAIT/OUT;
// sum_count_o counts accepted sums (wraps).
module flp_tree_sequencer #(
   parameter int NUM_INPUTS   = 10,
   parameter int EXP_WIDTH    = 9,
   parameter int MANT_WIDTH   = 8,
   parameter int TREE_LATENCY = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush_i,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic [MANT_WIDTH-1:0]            in_data_i,
   output logic [NUM_INPUTS*MANT_WIDTH-1:0] tree_bus_o,
   input  logic [EXP_WIDTH-1:0]             tree_exp_i,
   input  logic [MANT_WIDTH-1:0]            tree_mant_i,
   output logic                             sum_valid_o,
   input  logic                             sum_ready_i,
   output logic [EXP_WIDTH-1:0]             sum_exp_o,
   output logic [MANT_WIDTH-1:0]            sum_mant_o,
   output logic                             busy_o,
   output logic [15:0]                      sum_count_o
);
   localparam int IW = $clog2(NUM_INPUTS);
   localparam int CW = $clog2(TREE_LATENCY + 1);
   typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_OUT} state_t;
   state_t                          state_q, state_d;
   logic [IW-1:0]                   idx_q, idx_d;
   logic [CW-1:0]                   wait_q, wait_d;
   logic [NUM_INPUTS*MANT_WIDTH-1:0] bus_q, bus_d;
   logic [EXP_WIDTH-1:0]            exp_q, exp_d;
   logic [MANT_WIDTH-1:0]           mant_q, mant_d;
   logic [15:0]                     cnt_q, cnt_d;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOAD;
         idx_q   <= '0;
         wait_q  <= '0;
         bus_q   <= '0;
         exp_q   <= '0;
         mant_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         bus_q   <= bus_d;
         exp_q   <= exp_d;
         mant_q  <= mant_d;
         cnt_q   <= cnt_d;
      end
   end
   // Capture happens on the edge where wait_q is already zero, giving the tree TREE_LATENCY+1 edges of a stable bus.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      bus_d   = bus_q;
      exp_d   = exp_q;
      mant_d  = mant_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         state_d = ST_LOAD;
         idx_d   = '0;
         wait_d  = '0;
         bus_d   = '0;
      end else begin
         case (state_q)
            ST_LOAD: if (in_valid_i) begin
               bus_d[idx_q*MANT_WIDTH +: MANT_WIDTH] = in_data_i;
               idx_d   = (idx_q == IW'(NUM_INPUTS - 1)) ? '0 : idx_q + 1'b1;
               wait_d  = (idx_q == IW'(NUM_INPUTS - 1)) ? CW'(TREE_LATENCY) : wait_q;
               state_d = (idx_q == IW'(NUM_INPUTS - 1)) ? ST_WAIT : ST_LOAD;
            end
            ST_WAIT: if (wait_q == '0) begin
               exp_d   = tree_exp_i;
               mant_d  = tree_mant_i;
               state_d = ST_OUT;
            end else begin
               wait_d = wait_q - 1'b1;
            end
            ST_OUT: if (sum_ready_i) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
         endcase
      end
   end
   assign in_ready_o  = (state_q == ST_LOAD);
   assign sum_valid_o = (state_q == ST_OUT);
   assign busy_o      = (state_q == ST_WAIT) || (state_q == ST_OUT);
   assign tree_bus_o  = bus_q;
   assign sum_exp_o   = exp_q;
   assign sum_mant_o  = mant_q;
   assign sum_count_o = cnt_q;
endmodule

// File: tb/tb_flp_tree_sequencer.sv
// tb_flp_tree_sequencer: randomized and directed checks of flp_tree_sequencer against a sum-level reference model.
module tb_flp_tree_sequencer;
   localparam int N  = 10;
   localparam int E  = 9;
   localparam int M  = 8;
   localparam int TL = 4;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, sum_ready = 1'b0, preload = 1'b0;
   logic [M-1:0] in_data = '0;
   logic in_ready, sum_valid, busy;
   logic [N*M-1:0] tree_bus;
   logic [E-1:0] tree_exp, sum_exp;
   logic [M-1:0] tree_mant, sum_mant;
   logic [15:0] sum_count;
   int tests = 0, fails = 0;
   flp_tree_sequencer #(.NUM_INPUTS(N), .EXP_WIDTH(E), .MANT_WIDTH(M), .TREE_LATENCY(TL)) dut (
      .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_data_i(in_data), .tree_bus_o(tree_bus), .tree_exp_i(tree_exp), .tree_mant_i(tree_mant),
      .sum_valid_o(sum_valid), .sum_ready_i(sum_ready), .sum_exp_o(sum_exp), .sum_mant_o(sum_mant),
      .busy_o(busy), .sum_count_o(sum_count));
   always #5 clk = ~clk;
   // Stand-in adder tree: exponent = sum of codes, mantissa = xor of codes, TL register stages.
   function automatic logic [E-1:0] f_exp(input logic [N*M-1:0] b);
      logic [E-1:0] s = '0;
      for (int i = 0; i < N; i++) s = s + E'(b[i*M +: M]);
      return s;
   endfunction
   function automatic logic [M-1:0] f_mant(input logic [N*M-1:0] b);
      logic [M-1:0] x = '0;
      for (int i = 0; i < N; i++) x = x ^ b[i*M +: M];
      return x;
   endfunction
   logic [TL-1:0][E+M-1:0] pipe = '0;
   always @(posedge clk) pipe <= {pipe[TL-2:0], f_exp(tree_bus), f_mant(tree_bus)};
   assign {tree_exp, tree_mant} = pipe[TL-1];
   // Reference model: elements collected so far, cycles spent full, and whether a sum is on offer.
   int mn, mt;
   logic mhave;
   logic [N*M-1:0] mbus;
   logic [E-1:0] mexp;
   logic [M-1:0] mmant;
   logic [15:0] mcnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mn <= 0; mt <= 0; mhave <= 1'b0; mbus <= '0; mexp <= '0; mmant <= '0; mcnt <= '0;
      end else if (preload) begin
         mcnt <= 16'hFFFF;
      end else if (flush) begin
         mn <= 0; mt <= 0; mhave <= 1'b0; mbus <= '0;
      end else if (mhave) begin
         if (sum_ready) begin
            mhave <= 1'b0; mn <= 0; mcnt <= mcnt + 16'd1;
         end
      end else if (mn == N) begin
         if (mt == TL) begin
            mhave <= 1'b1; mexp <= f_exp(mbus); mmant <= f_mant(mbus);
         end else begin
            mt <= mt + 1;
         end
      end else if (in_valid) begin
         mbus[mn*M +: M] <= in_data; mn <= mn + 1; mt <= 0;
      end
   end
   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   logic pbusy = 1'b0;
   logic [N*M-1:0] pbus = '0;
   always @(negedge clk) begin
      if (!rst) begin
         check("in_ready", in_ready, !mhave && mn < N);
         check("sum_valid", sum_valid, mhave);
         check("busy", busy, mn == N);
         check("tree_bus", tree_bus, mbus);
         check("sum_exp", sum_exp, mexp);
         check("sum_mant", sum_mant, mmant);
         check("sum_count", sum_count, mcnt);
         if (busy && pbusy) check("bus_frozen", tree_bus, pbus);
         pbusy <= busy;
         pbus  <= tree_bus;
      end else begin
         pbusy <= 1'b0;
      end
   end
   task automatic push(input logic [M-1:0] d);
      in_valid = 1'b1; in_data = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask
   task automatic push_rand(input int n);
      for (int i = 0; i < n; i++) push(M'($urandom));
   endtask
   task automatic wait_sum(output int lo);
      lo = 0;
      for (int i = 0; i < 50 && !sum_valid; i++) begin
         if (!in_ready) lo++;
         @(negedge clk);
      end
      check("sum_valid_timeout", sum_valid, 1'b1);
   endtask
   task automatic take();
      sum_ready = 1'b1;
      @(negedge clk);
      sum_ready = 1'b0;
   endtask
   int lo;
   logic [15:0] c0;
   logic [E-1:0] hexp;
   logic [M-1:0] hmant;
   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_sum_valid", sum_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_bus", tree_bus, '0);
      check("rst_count", sum_count, 16'd0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 1; i <= N; i++) push(M'(i));
      wait_sum(lo);
      check("wait_cycles", lo, 5);
      check("bus_order", tree_bus, 80'h0A090807060504030201);
      check("lit_exp", sum_exp, 9'd55);
      check("lit_mant", sum_mant, 8'h0B);
      take();
      check("count_one", sum_count, 16'd1);
      check("ready_after_take", in_ready, 1'b1);
      for (int i = 1; i <= N; i++) begin
         push(M'(i));
         if (i == 3 || i == 7) repeat (2) @(negedge clk);
      end
      wait_sum(lo);
      check("gap_exp", sum_exp, 9'd55);
      check("gap_mant", sum_mant, 8'h0B);
      take();
      push_rand(N);
      wait_sum(lo);
      hexp = sum_exp; hmant = sum_mant; c0 = sum_count;
      repeat (20) begin
         @(negedge clk);
         check("hold_valid", sum_valid, 1'b1);
         check("hold_ready", in_ready, 1'b0);
         check("hold_data", {sum_exp, sum_mant}, {hexp, hmant});
      end
      take();
      check("release_count", sum_count, c0 + 16'd1);
      check("release_ready", in_ready, 1'b1);
      c0 = sum_count;
      push_rand(6);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_bus", tree_bus, '0);
      check("flush_ready", in_ready, 1'b1);
      check("flush_count", sum_count, c0);
      push_rand(N);
      wait_sum(lo);
      take();
      check("post_flush_count", sum_count, c0 + 16'd1);
      push_rand(N);
      wait_sum(lo);
      c0 = sum_count;
      sum_ready = 1'b1; flush = 1'b1;
      @(negedge clk);
      sum_ready = 1'b0; flush = 1'b0;
      check("flush_hs_valid", sum_valid, 1'b0);
      check("flush_hs_count", sum_count, c0);
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < N; k++) begin
            if ($urandom_range(3) == 0) repeat ($urandom_range(2, 1)) @(negedge clk);
            push(M'($urandom));
         end
         wait_sum(lo);
         repeat ($urandom_range(3)) @(negedge clk);
         take();
      end
      push_rand(N);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_in_ready", in_ready, 1'b1);
      check("arst_valid", sum_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_bus", tree_bus, '0);
      check("arst_sum", {sum_exp, sum_mant}, '0);
      check("arst_count", sum_count, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      preload = 1'b1;
      @(posedge clk);
      #1 force dut.cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.cnt_q;
      preload = 1'b0;
      push_rand(N);
      wait_sum(lo);
      check("pre_wrap", sum_count, 16'hFFFF);
      take();
      check("wrap", sum_count, 16'h0000);
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
